nibble_pattern_generator: RTL

//   Transmit-side companion of the 4-bit pattern detector. On start, replays a

---
 rtl/nibble_pattern_generator.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/nibble_pattern_generator.sv
// rtl/nibble_pattern_generator.sv - replays a latched nibble pattern as a valid-qualified stream
//
// Purpose: on start, sends the latched pattern (MS nibble first) repeats_i
// times, with gap_len_i idle cycles between repetitions, then pulses done_o.
// Optional feature macro: PATGEN_LFSR_FILL_EN. When it is defined, gap cycles
// carry valid filler nibbles from a 4-bit LFSR instead of being idle.
//
// Ports:
//   clk_i      clock, rising edge
//   rst_i      synchronous active-high reset
//   start_i    begin transmission (sampled only in IDLE)
//   pattern_i  pattern, NIBBLES*4 bits, MS nibble sent first
//   repeats_i  number of pattern repetitions
//   gap_len_i  cycles between repetitions
//   out_o      nibble data (0 when valid_o is low)
//   valid_o    out_o carries a nibble this cycle
//   busy_o     generator is not idle
//   done_o     one-cycle pulse at end of transmission
module nibble_pattern_generator #(
    parameter int NIBBLES = 4,
    parameter int CNT_W   = 4,
    parameter int GAP_W   = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic [NIBBLES*4-1:0] pattern_i,
    input  logic [CNT_W-1:0]     repeats_i,
    input  logic [GAP_W-1:0]     gap_len_i,
    output logic [3:0]           out_o,
    output logic                 valid_o,
    output logic                 busy_o,
    output logic                 done_o
);

    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_GAP,
        S_DONE
    } state_t;

    state_t               state_q, state_d;
    logic [NIBBLES*4-1:0] pat_q, pat_d;
    logic [CNT_W-1:0]     rep_q, rep_d;       // repetitions left, including the one in flight
    logic [GAP_W-1:0]     gap_len_q, gap_len_d;
    logic [GAP_W-1:0]     gap_cnt_q, gap_cnt_d; // gap cycles left, including the current one
    logic [IDX_W-1:0]     idx_q, idx_d;       // index of the nibble currently on out_o
    logic [3:0]           out_q, out_d;
    logic                 valid_q, valid_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
`ifdef PATGEN_LFSR_FILL_EN
    localparam logic [3:0] LFSR_SEED = 4'b1001;
    logic [3:0]           lfsr_q, lfsr_d;
`endif

    // Shift the wanted nibble up to the top instead of a variable part-select.
    function automatic logic [3:0] nibble_at(input logic [NIBBLES*4-1:0] p,
                                             input logic [IDX_W-1:0]     i);
        logic [NIBBLES*4-1:0] sh;
        sh = p << {i, 2'b00};
        return sh[NIBBLES*4-1 -: 4];
    endfunction

    // Outputs are registered, so each branch computes what the next cycle shows.
    always_comb begin
        state_d   = state_q;
        pat_d     = pat_q;
        rep_d     = rep_q;
        gap_len_d = gap_len_q;
        gap_cnt_d = gap_cnt_q;
        idx_d     = idx_q;
        out_d     = 4'h0;
        valid_d   = 1'b0;
        busy_d    = 1'b0;
        done_d    = 1'b0;
`ifdef PATGEN_LFSR_FILL_EN
        lfsr_d    = lfsr_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    pat_d     = pattern_i;
                    rep_d     = repeats_i;
                    gap_len_d = gap_len_i;
                    busy_d    = 1'b1;
`ifdef PATGEN_LFSR_FILL_EN
                    lfsr_d    = LFSR_SEED;
`endif
                    if (repeats_i != '0) begin
                        state_d = S_SEND;
                        idx_d   = '0;
                        out_d   = nibble_at(pattern_i, '0);
                        valid_d = 1'b1;
                    end else begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end
                end
            end
            S_SEND: begin
                busy_d = 1'b1;
                if (idx_q == LAST_IDX) begin
                    rep_d = rep_q - CNT_W'(1);
                    if (rep_q == CNT_W'(1)) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else if (gap_len_q != '0) begin
                        state_d   = S_GAP;
                        gap_cnt_d = gap_len_q;
`ifdef PATGEN_LFSR_FILL_EN
                        out_d     = lfsr_q;
                        valid_d   = 1'b1;
                        lfsr_d    = {lfsr_q[2:0], lfsr_q[3] ^ lfsr_q[2]};
`endif
                    end else begin
                        // Back-to-back repeat: nibble 0 follows the last without a bubble.
                        idx_d   = '0;
                        out_d   = nibble_at(pat_q, '0);
                        valid_d = 1'b1;
                    end
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                    out_d   = nibble_at(pat_q, idx_q + IDX_W'(1));
                    valid_d = 1'b1;
                end
            end
            S_GAP: begin
                busy_d = 1'b1;
                if (gap_cnt_q == GAP_W'(1)) begin
                    state_d = S_SEND;
                    idx_d   = '0;
                    out_d   = nibble_at(pat_q, '0);
                    valid_d = 1'b1;
                end else begin
                    gap_cnt_d = gap_cnt_q - GAP_W'(1);
`ifdef PATGEN_LFSR_FILL_EN
                    out_d     = lfsr_q;
                    valid_d   = 1'b1;
                    lfsr_d    = {lfsr_q[2:0], lfsr_q[3] ^ lfsr_q[2]};
`endif
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            pat_q     <= '0;
            rep_q     <= '0;
            gap_len_q <= '0;
            gap_cnt_q <= '0;
            idx_q     <= '0;
            out_q     <= 4'h0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef PATGEN_LFSR_FILL_EN
            lfsr_q    <= LFSR_SEED;
`endif
        end else begin
            state_q   <= state_d;
            pat_q     <= pat_d;
            rep_q     <= rep_d;
            gap_len_q <= gap_len_d;
            gap_cnt_q <= gap_cnt_d;
            idx_q     <= idx_d;
            out_q     <= out_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
`ifdef PATGEN_LFSR_FILL_EN
            lfsr_q    <= lfsr_d;
`endif
        end
    end

    assign out_o   = out_q;
    assign valid_o = valid_q;
    assign busy_o  = busy_q;
    assign done_o  = done_q;

endmodule
